// File: rtl/mips_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_wb_pkg
// Brief   : Shared types and constants for the writeback stage.
// Revision: 1.0 - initial release
// ============================================================================
package mips_wb_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    LWU = 3'd5,
    LD  = 3'd6
  } ld_type_e;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  localparam int c_byte_w = 8;
  localparam int c_half_w = 16;
  localparam int c_word_w = 32;

  // A narrow datapath folds LD onto LW, so only the low two lane bits matter there.
  function automatic logic is_misaligned(input ld_type_e t, input logic [2:0] a,
                                         input logic wide);
    case (t)
      LH, LHU: return a[0];
      LW, LWU: return |a[1:0];
      LD:      return wide ? |a : |a[1:0];
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module  : load_align
// Brief   : Combinational byte-lane select and sign/zero extension of load data.
// Revision: 1.0 - initial release
// ============================================================================
module load_align
  import mips_wb_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0] rdata,
  input  ld_type_e     ld_type,
  input  logic [2:0]   addr_lo,
  output logic [N-1:0] aligned
);

  if (N == 64) begin : g_n64
    logic [N-1:0] w_s;
    assign w_s = rdata >> {addr_lo, 3'b000};

    always_comb begin
      aligned = '0;
      case (ld_type)
        LB:      aligned = {{(N-c_byte_w){w_s[c_byte_w-1]}}, w_s[c_byte_w-1:0]};
        LBU:     aligned = {{(N-c_byte_w){1'b0}}, w_s[c_byte_w-1:0]};
        LH:      aligned = {{(N-c_half_w){w_s[c_half_w-1]}}, w_s[c_half_w-1:0]};
        LHU:     aligned = {{(N-c_half_w){1'b0}}, w_s[c_half_w-1:0]};
        LW:      aligned = {{(N-c_word_w){w_s[c_word_w-1]}}, w_s[c_word_w-1:0]};
        LWU:     aligned = {{(N-c_word_w){1'b0}}, w_s[c_word_w-1:0]};
        LD:      aligned = w_s;
        default: aligned = '0;
      endcase
    end
  end else begin : g_n32
    logic [N-1:0] w_s;
    logic         w_unused_lane;
    assign w_s           = rdata >> {addr_lo[1:0], 3'b000};
    assign w_unused_lane = addr_lo[2];

    always_comb begin
      aligned = '0;
      case (ld_type)
        LB:          aligned = {{(N-c_byte_w){w_s[c_byte_w-1]}}, w_s[c_byte_w-1:0]};
        LBU:         aligned = {{(N-c_byte_w){1'b0}}, w_s[c_byte_w-1:0]};
        LH:          aligned = {{(N-c_half_w){w_s[c_half_w-1]}}, w_s[c_half_w-1:0]};
        LHU:         aligned = {{(N-c_half_w){1'b0}}, w_s[c_half_w-1:0]};
        LW, LWU, LD: aligned = w_s;
        default:     aligned = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : wb_stage
// Brief   : Writeback stage: waits for load data, aligns it, drives the regfile port.
// Revision: 1.0 - initial release
// ============================================================================
module wb_stage
  import mips_wb_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_regwrite,
  input  logic         in_memtoreg,
  input  logic [4:0]   in_wa,
  input  logic [N-1:0] in_alu,
  input  logic [2:0]   in_ld_type,
  input  logic [2:0]   in_addr_lo,
  input  logic         mem_rvalid,
  input  logic [N-1:0] mem_rdata,
  output logic         we3,
  output logic [4:0]   wa3,
  output logic [N-1:0] wd3,
  output logic         busy,
  output logic         err
);

  wb_state_e    r_state;
  wb_state_e    w_state_next;
  logic [4:0]   r_wa;
  ld_type_e     r_ld_type;
  logic [2:0]   r_addr_lo;
  logic         r_regwrite;

  ld_type_e     w_ld_type;
  logic         w_accept;
  logic         w_misaligned;
  logic         w_alu_accept;
  logic         w_load_accept;
  logic         w_load_done;
  logic [N-1:0] w_aligned;

  assign w_ld_type     = ld_type_e'(in_ld_type);
  assign w_accept      = in_valid && in_ready;
  assign w_misaligned  = is_misaligned(w_ld_type, in_addr_lo, (N == 64));
  assign w_alu_accept  = w_accept && !in_memtoreg;
  assign w_load_accept = w_accept && in_memtoreg && !w_misaligned;
  assign w_load_done   = (r_state == WAIT_MEM) && mem_rvalid;

  load_align #(.N(N)) u_align (
    .rdata   (mem_rdata),
    .ld_type (r_ld_type),
    .addr_lo (r_addr_lo),
    .aligned (w_aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (w_load_accept) w_state_next = WAIT_MEM;
      WAIT_MEM: if (mem_rvalid)    w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (r_state)
      IDLE:     in_ready = 1'b1;
      WAIT_MEM: busy     = 1'b1;
      default:  in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wa       <= '0;
      r_ld_type  <= LB;
      r_addr_lo  <= '0;
      r_regwrite <= 1'b0;
    end else if (w_load_accept) begin
      r_wa       <= in_wa;
      r_ld_type  <= w_ld_type;
      r_addr_lo  <= in_addr_lo;
      r_regwrite <= in_regwrite;
    end
  end

  // Register 0 is hardwired zero in the regfile, so a write to it is suppressed here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else begin
      we3 <= 1'b0;
      if (w_alu_accept) begin
        we3 <= in_regwrite && (in_wa != 5'd0);
        wa3 <= in_wa;
        wd3 <= in_alu;
      end else if (w_load_done) begin
        we3 <= r_regwrite && (r_wa != 5'd0);
        wa3 <= r_wa;
        wd3 <= w_aligned;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((w_accept && in_memtoreg && w_misaligned) ||
                 ((r_state == IDLE) && mem_rvalid)) begin
      err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_stage
// Brief   : Directed self-checking bench for wb_stage at N=64.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_regwrite;
  logic         in_memtoreg;
  logic [4:0]   in_wa;
  logic [N-1:0] in_alu;
  logic [2:0]   in_ld_type;
  logic [2:0]   in_addr_lo;
  logic         mem_rvalid;
  logic [N-1:0] mem_rdata;
  logic         we3;
  logic [4:0]   wa3;
  logic [N-1:0] wd3;
  logic         busy;
  logic         err;

  int n_chk = 0;
  int n_bad = 0;

  wb_stage #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_regwrite (in_regwrite),
    .in_memtoreg (in_memtoreg),
    .in_wa       (in_wa),
    .in_alu      (in_alu),
    .in_ld_type  (in_ld_type),
    .in_addr_lo  (in_addr_lo),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .we3         (we3),
    .wa3         (wa3),
    .wd3         (wd3),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid    = 1'b0;
    in_regwrite = 1'b0;
    in_memtoreg = 1'b0;
    in_wa       = '0;
    in_alu      = '0;
    in_ld_type  = '0;
    in_addr_lo  = '0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
  endtask

  task automatic do_reset;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we3", we3, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic alu_write(input logic [4:0] wa, input logic [63:0] alu);
    in_valid = 1'b1; in_memtoreg = 1'b0; in_regwrite = 1'b1;
    in_wa = wa; in_alu = alu;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [2:0] t, input logic [2:0] a,
                          input logic [4:0] wa, input logic [63:0] rd,
                          input logic [63:0] exp_wd);
    in_valid = 1'b1; in_memtoreg = 1'b1; in_regwrite = 1'b1;
    in_ld_type = t; in_addr_lo = a; in_wa = wa;
    tick;
    in_valid = 1'b0; in_memtoreg = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_we_wait"}, we3, 0);
    tick;
    chk({tag, "_busy2"}, busy, 1);
    mem_rvalid = 1'b1; mem_rdata = rd;
    tick;
    mem_rvalid = 1'b0;
    chk({tag, "_we"}, we3, 1);
    chk({tag, "_wa"}, wa3, 64'(wa));
    chk({tag, "_wd"}, wd3, exp_wd);
    chk({tag, "_rdy_after"}, in_ready, 1);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk("reset_we3", we3, 0);
    chk("reset_wa3", wa3, 0);
    chk("reset_wd3", wd3, 0);
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("reset_rdy", in_ready, 1);

    alu_write(5'd5, 64'h1234);
    chk("alu_we", we3, 1);
    chk("alu_wa", wa3, 5);
    chk("alu_wd", wd3, 64'h1234);
    tick;
    chk("alu_we_off", we3, 0);

    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_memtoreg = 1'b0; in_regwrite = 1'b1;
      in_wa = 5'(i); in_alu = 64'(i * 'h11);
      chk("b2b_rdy", in_ready, 1);
      tick;
      chk("b2b_we", we3, 1);
      chk("b2b_wa", wa3, 64'(i));
      chk("b2b_wd", wd3, 64'(i * 'h11));
    end
    in_valid = 1'b0;
    tick;
    chk("b2b_we_off", we3, 0);

    run_load("lb",  3'd0, 3'd3, 5'd7,  64'h00000000_80FF0000, 64'hFFFFFFFF_FFFFFF80);
    run_load("lhu", 3'd3, 3'd2, 5'd8,  64'h00000000_80010000, 64'h00000000_00008001);
    run_load("lwu", 3'd5, 3'd4, 5'd9,  64'hDEADBEEF_00000000, 64'h00000000_DEADBEEF);
    run_load("lh",  3'd2, 3'd6, 5'd10, 64'hF00D0000_00000000, 64'hFFFFFFFF_FFFFF00D);
    run_load("lw",  3'd4, 3'd0, 5'd11, 64'h00000000_80000000, 64'hFFFFFFFF_80000000);
    run_load("ld",  3'd6, 3'd0, 5'd12, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF);
    run_load("lbu", 3'd1, 3'd7, 5'd13, 64'hA5000000_00000000, 64'h00000000_000000A5);
    chk("no_err_yet", err, 0);

    alu_write(5'd0, 64'h55);
    chk("r0_we", we3, 0);

    in_valid = 1'b1; in_memtoreg = 1'b1; in_regwrite = 1'b1;
    in_ld_type = 3'd2; in_addr_lo = 3'd1; in_wa = 5'd4;
    tick;
    in_valid = 1'b0; in_memtoreg = 1'b0;
    chk("mis_err", err, 1);
    chk("mis_we", we3, 0);
    chk("mis_rdy", in_ready, 1);
    chk("mis_busy", busy, 0);
    tick;
    chk("mis_we2", we3, 0);

    do_reset();
    tick;
    chk("spur_pre_err", err, 0);
    mem_rvalid = 1'b1; mem_rdata = 64'h77;
    tick;
    mem_rvalid = 1'b0;
    chk("spur_err", err, 1);
    chk("spur_we", we3, 0);

    do_reset();
    tick;
    alu_write(5'd12, 64'hABC);
    chk("mid_pre_wa", wa3, 12);
    in_valid = 1'b1; in_memtoreg = 1'b1; in_regwrite = 1'b1;
    in_ld_type = 3'd4; in_addr_lo = 3'd0; in_wa = 5'd9;
    tick;
    in_valid = 1'b0; in_memtoreg = 1'b0;
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_async_we3", we3, 0);
    chk("mid_async_wa3", wa3, 0);
    chk("mid_async_wd3", wd3, 0);
    chk("mid_async_busy", busy, 0);
    chk("mid_async_err", err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    chk("mid_rdy", in_ready, 1);
    chk("mid_we", we3, 0);
    mem_rvalid = 1'b1; mem_rdata = 64'h1111_2222;
    tick;
    mem_rvalid = 1'b0;
    chk("mid_late_err", err, 1);
    chk("mid_late_we", we3, 0);
    tick;
    chk("mid_late_we2", we3, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
